// File: rtl/pipe_field.sv
// pipe_field: scrolls two pipes, respawns them with new gaps, flags bird/pipe/floor collisions and counts cleared pipes.
// Optional macro LFSR_GAP_EN: respawn gaps come from an 8-bit LFSR; when undefined every respawn gap is 160.
module pipe_field #(
  parameter int SCREEN_W     = 640,
  parameter int PIPE_W       = 60,
  parameter int PIPE_SPACING = 360,
  parameter int GAP_H        = 150,
  parameter int BIRD_SIZE    = 20,
  parameter int FLOOR_Y      = 460,
  parameter int SCROLL_DIV   = 400000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [9:0]  YBird,
  input  logic [9:0]  XBird,
  output logic [10:0] PipeX0,
  output logic [10:0] PipeX1,
  output logic [9:0]  GapY0,
  output logic [9:0]  GapY1,
  output logic [7:0]  Score,
  output logic        Hit,
  output logic        GameOver
);
  localparam int INIT0   = SCREEN_W + PIPE_W;
  localparam int INIT1   = INIT0 + PIPE_SPACING;
  localparam int RESPAWN = 2 * PIPE_SPACING - 1;
  localparam int CW      = $clog2(SCROLL_DIV);
  localparam logic [9:0] GAP_DEF = 10'd160;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HIT} state_t;

  state_t          r_state, w_state_nxt;
  logic            w_game_over;
  logic [10:0]     r_px0, r_px1;
  logic [9:0]      r_gy0, r_gy1;
  logic [7:0]      r_score;
  logic            r_hit;
  logic [CW-1:0]   r_cnt;
  logic            w_tick, w_adv, w_init, w_hit;
  logic            w_resp0, w_resp1, w_sc0, w_sc1;
  logic [9:0]      w_gap0, w_gap1;
  logic [8:0]      w_score_sum;

  function automatic logic pipe_overlap(input logic [11:0] px, input logic [11:0] gy,
                                        input logic [11:0] xb, input logic [11:0] yb);
    return (xb < px) && (xb + 12'(BIRD_SIZE + PIPE_W) > px) &&
           ((yb < gy) || (yb + 12'(BIRD_SIZE) > gy + 12'(GAP_H)));
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_nxt = S_RUN;
      S_RUN:   if (r_hit) w_state_nxt = S_HIT;
      S_HIT:   if (Start) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_game_over = (r_state == S_HIT);
  end

  assign w_tick  = (r_cnt == CW'(SCROLL_DIV - 1));
  assign w_adv   = (r_state == S_RUN) && w_tick && !r_hit;
  // Leaving HIT loads the idle values on the same edge so IDLE never shows the frozen field.
  assign w_init  = (r_state == S_IDLE) || ((r_state == S_HIT) && Start);
  assign w_resp0 = (r_px0 == 11'd0);
  assign w_resp1 = (r_px1 == 11'd0);
  assign w_sc0   = (r_px0 == {1'b0, XBird});
  assign w_sc1   = (r_px1 == {1'b0, XBird});
  assign w_score_sum = {1'b0, r_score} + 9'(w_sc0) + 9'(w_sc1);

  assign w_hit = pipe_overlap(12'(r_px0), 12'(r_gy0), 12'(XBird), 12'(YBird)) ||
                 pipe_overlap(12'(r_px1), 12'(r_gy1), 12'(XBird), 12'(YBird)) ||
                 (12'(YBird) + 12'(BIRD_SIZE) > 12'(FLOOR_Y));

`ifdef LFSR_GAP_EN
  logic [7:0] r_lfsr, w_lfsr_a, w_lfsr_b;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Pipe 0 consumes the first step when both pipes respawn on one tick.
  assign w_lfsr_a = lfsr_step(r_lfsr);
  assign w_lfsr_b = lfsr_step(w_lfsr_a);
  assign w_gap0   = 10'd40 + {2'b00, w_lfsr_a};
  assign w_gap1   = 10'd40 + {2'b00, (w_resp0 ? w_lfsr_b : w_lfsr_a)};

  always_ff @(posedge Clk) begin
    if (Reset)                              r_lfsr <= 8'hA5;
    else if (w_adv && w_resp0 && w_resp1)   r_lfsr <= w_lfsr_b;
    else if (w_adv && (w_resp0 || w_resp1)) r_lfsr <= w_lfsr_a;
  end
`else
  assign w_gap0 = GAP_DEF;
  assign w_gap1 = GAP_DEF;
`endif

  always_ff @(posedge Clk) begin
    if (Reset || w_init) begin
      r_px0   <= 11'(INIT0);
      r_px1   <= 11'(INIT1);
      r_gy0   <= GAP_DEF;
      r_gy1   <= GAP_DEF;
      r_score <= 8'd0;
      r_hit   <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_hit <= w_hit;
      r_cnt <= (r_hit || w_tick) ? '0 : r_cnt + 1'b1;
      if (w_adv) begin
        r_px0   <= w_resp0 ? 11'(RESPAWN) : r_px0 - 11'd1;
        r_px1   <= w_resp1 ? 11'(RESPAWN) : r_px1 - 11'd1;
        if (w_resp0) r_gy0 <= w_gap0;
        if (w_resp1) r_gy1 <= w_gap1;
        r_score <= w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
      end
    end
  end

  assign PipeX0   = r_px0;
  assign PipeX1   = r_px1;
  assign GapY0    = r_gy0;
  assign GapY1    = r_gy1;
  assign Score    = r_score;
  assign Hit      = r_hit;
  assign GameOver = w_game_over;
endmodule

// File: tb/tb_pipe_field.sv
// Bench for pipe_field: directed vector table, hand-written corner sequences and random play against a reference model.
module tb_pipe_field;
  localparam int DIV = 4;
`ifdef LFSR_GAP_EN
  localparam int GAP_A = 114;
  localparam int GAP_B = 189;
`else
  localparam int GAP_A = 160;
  localparam int GAP_B = 160;
`endif
  localparam int MI = 0, MR = 1, MH = 2;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [9:0]  yb, xb;
  logic [10:0] px0, px1;
  logic [9:0]  gy0, gy1;
  logic [7:0]  score;
  logic        hit, go;

  int n_chk = 0;
  int n_fail = 0;

  int m_st, m_score, m_hit, m_cnt, m_lfsr;
  int m_px[2];
  int m_gy[2];

  always #5 clk = ~clk;

  pipe_field #(.SCROLL_DIV(DIV)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .YBird(yb), .XBird(xb),
    .PipeX0(px0), .PipeX1(px1), .GapY0(gy0), .GapY1(gy1),
    .Score(score), .Hit(hit), .GameOver(go)
  );

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v << 1) | fb) & 255;
  endfunction

  function automatic bit overlaps(input int px, input int gy, input int x, input int y);
    return (x < px) && (x + 80 > px) && ((y < gy) || (y + 20 > gy + 150));
  endfunction

  task automatic model_init();
    m_px[0] = 700; m_px[1] = 1060;
    m_gy[0] = 160; m_gy[1] = 160;
    m_score = 0; m_hit = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int  x, y;
    bit  nh;
    x = int'(xb);
    y = int'(yb);
    if (rst) begin
      model_init();
      m_lfsr = 165;
      m_st = MI;
    end else if (m_st == MI) begin
      model_init();
      if (start) m_st = MR;
    end else if (m_st == MR) begin
      nh = overlaps(m_px[0], m_gy[0], x, y) || overlaps(m_px[1], m_gy[1], x, y) || (y + 20 > 460);
      if (m_hit == 0) begin
        if (m_cnt == DIV - 1) begin
          for (int p = 0; p < 2; p++) begin
            if (m_px[p] == x && m_score < 255) m_score++;
            if (m_px[p] == 0) begin
              m_px[p] = 719;
`ifdef LFSR_GAP_EN
              m_lfsr = lfsr_next(m_lfsr);
              m_gy[p] = 40 + m_lfsr;
`else
              m_gy[p] = 160;
`endif
            end else begin
              m_px[p] = m_px[p] - 1;
            end
          end
        end
        m_cnt = (m_cnt + 1) % DIV;
        m_st = MR;
      end else begin
        m_cnt = 0;
        m_st = MH;
      end
      m_hit = nh ? 1 : 0;
    end else begin
      if (start) begin
        model_init();
        m_st = MI;
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    n_chk++;
    if (int'(px0) != m_px[0] || int'(px1) != m_px[1] || int'(gy0) != m_gy[0] ||
        int'(gy1) != m_gy[1] || int'(score) != m_score || int'(hit) != m_hit ||
        int'(go) != ((m_st == MH) ? 1 : 0)) begin
      n_fail++;
      $display("FAIL model t=%0t: got px=%0d/%0d gy=%0d/%0d sc=%0d hit=%0b go=%0b, expected px=%0d/%0d gy=%0d/%0d sc=%0d hit=%0d go=%0d",
               $time, px0, px1, gy0, gy1, score, hit, go, m_px[0], m_px[1], m_gy[0], m_gy[1],
               m_score, m_hit, (m_st == MH) ? 1 : 0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic start_round();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  typedef struct {
    string nm;
    int    y, x, n;
    int    e_px0, e_score, e_hit, e_go;
  } vec_t;

  vec_t vt[7];

  initial begin
    rst = 1'b0; start = 1'b0; yb = 10'd200; xb = 10'd500;
    m_st = MI; m_lfsr = 165; model_init();

    // Vectors: reset, one-cycle Start, then hold the bird for n cycles (4 cycles per tick).
    vt[0] = '{"scroll10",   200, 500, 40,  690, 0, 0, 0};
    vt[1] = '{"floor440",   440, 500, 40,  690, 0, 0, 0};
    vt[2] = '{"floor441",   441, 500, 40,  700, 0, 1, 1};
    vt[3] = '{"pipe_hit",   100, 500, 600, 579, 0, 1, 1};
    vt[4] = '{"score201",   200, 500, 804, 499, 1, 0, 0};
    vt[5] = '{"wrap_top",   1020, 500, 40, 700, 0, 1, 1};
    vt[6] = '{"score_x680", 200, 680, 84,  679, 1, 0, 0};

    // Idle hold after reset.
    do_reset();
    run(100);
    chk("idle_px0", int'(px0), 700);
    chk("idle_px1", int'(px1), 1060);
    chk("idle_gy0", int'(gy0), 160);
    chk("idle_gy1", int'(gy1), 160);
    chk("idle_score", int'(score), 0);
    chk("idle_hit", int'(hit), 0);
    chk("idle_go", int'(go), 0);

    for (int i = 0; i < 7; i++) begin
      yb = 10'(vt[i].y); xb = 10'(vt[i].x);
      do_reset();
      start_round();
      run(vt[i].n);
      chk({vt[i].nm, "_px0"}, int'(px0), vt[i].e_px0);
      chk({vt[i].nm, "_score"}, int'(score), vt[i].e_score);
      chk({vt[i].nm, "_hit"}, int'(hit), vt[i].e_hit);
      chk({vt[i].nm, "_go"}, int'(go), vt[i].e_go);
    end

    // Pipe collision latency and return to IDLE.
    yb = 10'd100; xb = 10'd500;
    do_reset();
    start_round();
    run(4 * 121);
    chk("col_px0_579", int'(px0), 579);
    chk("col_hit_pre", int'(hit), 0);
    cycle();
    chk("col_hit", int'(hit), 1);
    chk("col_go_pre", int'(go), 0);
    cycle();
    chk("col_go", int'(go), 1);
    run(20);
    chk("col_frozen", int'(px0), 579);
    start = 1'b1; cycle(); start = 1'b0;
    chk("col_idle_px0", int'(px0), 700);
    chk("col_idle_go", int'(go), 0);

    // Floor boundary inside one round.
    yb = 10'd440; xb = 10'd100;
    do_reset();
    start_round();
    run(40);
    chk("floor_440_hit", int'(hit), 0);
    yb = 10'd441;
    cycle();
    chk("floor_441_hit", int'(hit), 1);
    chk("floor_441_go_pre", int'(go), 0);
    cycle();
    chk("floor_441_go", int'(go), 1);
    start = 1'b1; cycle(); start = 1'b0;
    chk("floor_idle_score", int'(score), 0);
    chk("floor_idle_px1", int'(px1), 1060);

    // Long run through respawns, then reset mid-run and replay the first respawn.
    yb = 10'd200; xb = 10'd500;
    do_reset();
    start_round();
    run(4 * 200);
    chk("t200_score", int'(score), 0);
    run(4);
    chk("t201_score", int'(score), 1);
    chk("t201_px0", int'(px0), 499);
    run(4 * 360);
    chk("t561_score", int'(score), 2);
    chk("t561_px1", int'(px1), 499);
    run(4 * 139);
    chk("t700_px0", int'(px0), 0);
    run(4);
    chk("t701_px0", int'(px0), 719);
    chk("t701_gy0", int'(gy0), GAP_A);
    chk("t701_spacing", int'(px0) - int'(px1), 360);
    run(4 * 400);
    chk("t1101_px1", int'(px1), 679);
    chk("t1101_gy1", int'(gy1), GAP_B);
    chk("t1101_score", int'(score), 3);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("mrst_px0", int'(px0), 700);
    chk("mrst_gy1", int'(gy1), 160);
    chk("mrst_score", int'(score), 0);
    chk("mrst_go", int'(go), 0);
    start_round();
    run(4 * 701);
    chk("re_px0", int'(px0), 719);
    chk("re_gy0", int'(gy0), GAP_A);

    // Random play against the model.
    for (int ep = 0; ep < 6; ep++) begin
      xb = 10'($urandom_range(80, 620));
      yb = 10'($urandom_range(150, 300));
      do_reset();
      start_round();
      for (int c = 0; c < 2000; c++) begin
        if (c % 50 == 0) yb = 10'($urandom_range(140, 330));
        if ($urandom_range(0, 199) == 0) yb = 10'($urandom_range(0, 1023));
        if (c % 600 == 0) xb = 10'($urandom_range(0, 700));
        start = ($urandom_range(0, 299) == 0);
        rst   = ($urandom_range(0, 2499) == 0);
        cycle();
      end
      start = 1'b0; rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
